segment_scan_ctrl: RTL
======================

SEGMENT_SCAN_CTRL -- requirements
Module: segment_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles per digit slot.
REQ-002 SHALL have parameter BLANK_CYC, default 500: dead-time cycles at the start of each slot; legal range 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port Enable, input, 1: 1 = scanning, 0 = display dark.
REQ-006 SHALL have port Value, input, 16: four hex digits; [3:0] is digit 0.
REQ-007 SHALL have port Load, input, 1: single-cycle strobe that captures Value.
REQ-008 SHALL have port Seg, output, 7: segment drive; active-low, 0 = lit.
REQ-009 SHALL have port Anode, output, 4: digit select; active-low, bit n = digit n.
REQ-010 SHALL have port FrameDone, output, 1: one-cycle pulse at each frame wrap.

Function
REQ-011 SHALL implement FSM states IDLE, BLANK and ON.
REQ-012 IDLE SHALL hold Anode=4'b1111 and Seg=7'h7F; Enable=1 SHALL move the FSM to BLANK with digit index 0.
REQ-013 BLANK SHALL last exactly BLANK_CYC cycles with Anode=4'b1111 and Seg already showing the current digit's code; it SHALL then move to ON.
REQ-014 ON SHALL last exactly SCAN_DIV-BLANK_CYC cycles with only Anode[idx]=0; it SHALL then move to BLANK with idx+1, wrapping 3->0.
REQ-015 Each slot SHALL be exactly SCAN_DIV cycles, and each frame exactly 4*SCAN_DIV cycles, with no gaps.
REQ-016 Seg and Anode SHALL be registered outputs, and Seg SHALL change only on a BLANK entry.
REQ-017 A Load cycle SHALL capture Value into a pending register and set a pending flag; a later Load before the wrap SHALL overwrite it.
REQ-018 On the 3->0 wrap, the pending register SHALL copy into the display shadow, the flag SHALL clear, and FrameDone SHALL pulse in the first BLANK cycle of digit 0.
REQ-019 If Load coincides with the wrap cycle, the new Value SHALL go directly into the shadow, with no extra frame of delay.
REQ-020 Enable=0 in any state SHALL force IDLE on the next edge (Anode=4'b1111, Seg=7'h7F), preserving the shadow and pending register.
REQ-021 Re-enabling SHALL always restart the scan at BLANK of digit 0.
REQ-022 Slot counters SHALL be sized ceil(log2(SCAN_DIV)) bits and SHALL NOT overflow for any legal parameter value.

Reset
REQ-023 Rst=1 SHALL immediately, without a clock edge, force: state IDLE, idx 0, Anode=4'b1111, Seg=7'h7F, FrameDone=0, shadow 16'h0000, pending register 16'h0000, pending flag 0.
REQ-024 Rst asserted mid-slot SHALL abandon the slot, and after Rst is released scanning SHALL resume from BLANK of digit 0 if Enable=1.

Configuration
REQ-025 With macro SEG_LZB_EN defined, digits 3..1 SHALL be blanked (Anode bit held 1, Seg=7'h7F) during their ON slot when that digit and all higher digits of the shadow are zero.
REQ-026 Under SEG_LZB_EN, digit 0 SHALL never be blanked, and slot timing and FrameDone SHALL be unchanged.
REQ-027 Without SEG_LZB_EN, all four digits SHALL be displayed unconditionally.

Structure
REQ-028 State encoding, segment code constants (0..F active-low, blank=7'h7F) and the Anode-off constant SHALL live in shared package seg_pkg.
REQ-029 Hex-to-segment conversion SHALL be the single sub-module SegmentDecoder, instantiated once on the shadow register.
REQ-030 All other logic SHALL be a single always block for the FSM and counters plus a registered output stage.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-031 Rst, then Enable=1 and Load with Value=16'h1234 -> Anode cycles 1110, 1101, 1011, 0111, each low for 6 cycles after 2 cycles of 1111; Seg in slot 0 = 7'b0011001, FrameDone period = 32 cycles.
REQ-032 Load of 16'hABCD during slot 1 -> 16'h1234 is held to the end of the frame; after FrameDone, slot 0 Seg = 7'b0100001 and slot 3 Seg = 7'b0001000.
REQ-033 Load coincident with the wrap cycle -> the new value appears in slot 0 of the immediately following frame.
REQ-034 Enable=0 in the third ON cycle of slot 2 -> next edge Anode=4'b1111 and Seg=7'h7F; Enable=1 -> 2 BLANK cycles, then Anode=4'b1110.
REQ-035 Rst pulsed asynchronously mid-ON -> Anode=4'b1111 before the next Clk edge; shadow reads 16'h0000 (Seg=7'b1000000 in slot 0).
REQ-036 With SEG_LZB_EN, Value=16'h0005 -> slots 3..1 keep Anode=4'b1111 and slot 0 shows 7'b0010010; Value=16'h0000 -> slot 0 shows 7'b1000000.

Source files
------------

// File: rtl/segment_scan_ctrl_pkg.sv
// Shared definitions for the segment scan controller: FSM states, active-low
// segment codes (gfedcba, 0 = lit) and the all-digits-off anode pattern.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ON    = 2'd2
    } state_t;

    localparam logic [3:0] ANODE_OFF = 4'hF;
    localparam logic [6:0] SEG_OFF   = 7'h7F;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;
    localparam logic [6:0] SEG_A = 7'h08;
    localparam logic [6:0] SEG_B = 7'h03;
    localparam logic [6:0] SEG_C = 7'h46;
    localparam logic [6:0] SEG_D = 7'h21;
    localparam logic [6:0] SEG_E = 7'h06;
    localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/segment_scan_ctrl_decoder.sv
// Hex nibble to active-low seven-segment code.
module SegmentDecoder
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/segment_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with per-slot dead time
// and frame-synchronous value update. Define SEG_LZB_EN for leading-zero blanking.
module segment_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
)
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Enable,
    input  logic [15:0] Value,
    input  logic        Load,
    output logic [6:0]  Seg,
    output logic [3:0]  Anode,
    output logic        FrameDone
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [1:0]      idx, idx_nxt;
    logic [15:0]     shadow, shadow_nxt, pending;
    logic            pend_flag;
    logic            wrap;
    logic [3:0]      digit;
    logic [6:0]      code;
    logic            lzb;
    logic [6:0]      seg_nxt;
    logic [3:0]      anode_nxt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shadow    <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shadow <= shadow_nxt;
            if (Load)
                pending <= Value;
            if (wrap)
                pend_flag <= 1'b0;
            else if (Load)
                pend_flag <= 1'b1;
        end
    end

    // One counter spans the whole slot; BLANK ends at BLANK_CYC-1, ON at SCAN_DIV-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CW'(1);
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
            BLANK: begin
                if (cnt == CW'(BLANK_CYC - 1))
                    state_nxt = ON;
            end
            ON: begin
                if (cnt == CW'(SCAN_DIV - 1)) begin
                    state_nxt = BLANK;
                    cnt_nxt   = '0;
                    idx_nxt   = idx + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase
        if (!Enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end
    end

    always_comb begin
        wrap       = Enable && (state == ON) && (cnt == CW'(SCAN_DIV - 1)) && (idx == 2'd3);
        shadow_nxt = shadow;
        if (wrap)
            shadow_nxt = Load ? Value : (pend_flag ? pending : shadow);
    end

    // Decoding the next shadow lets the digit-0 code reflect a wrap-cycle update at once.
    always_comb digit = shadow_nxt[{idx_nxt, 2'b00} +: 4];

    SegmentDecoder u_dec (
        .hex (digit),
        .seg (code)
    );

`ifdef SEG_LZB_EN
    always_comb begin
        case (idx_nxt)
            2'd3:    lzb = (shadow_nxt[15:12] == 4'h0);
            2'd2:    lzb = (shadow_nxt[15:8]  == 8'h00);
            2'd1:    lzb = (shadow_nxt[15:4]  == 12'h000);
            default: lzb = 1'b0;
        endcase
    end
`else
    always_comb lzb = 1'b0;
`endif

    always_comb begin
        seg_nxt   = SEG_OFF;
        anode_nxt = ANODE_OFF;
        case (state_nxt)
            BLANK: seg_nxt = lzb ? SEG_OFF : code;
            ON: begin
                seg_nxt = lzb ? SEG_OFF : code;
                if (!lzb)
                    anode_nxt = ~(4'b0001 << idx_nxt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Seg       <= SEG_OFF;
            Anode     <= ANODE_OFF;
            FrameDone <= 1'b0;
        end else begin
            Seg       <= seg_nxt;
            Anode     <= anode_nxt;
            FrameDone <= wrap;
        end
    end

endmodule
